pov_string_reader: RTL

- Consumer side of the string builder. Snapshots the 77-bit character string when the builder signals it is complete.
- On every rotation-sensor sync pulse, plays the snapshot out one 7-bit character at a time to the POV glyph renderer over a valid/ready handshake.
- Sits between the string builder outputs (string, completeOut, changeOut) and the column/LED driver.

---
 rtl/pov_pkg.sv | 30 +++
 rtl/pov_sync_edge.sv | 23 ++
 rtl/pov_string_reader.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/pov_pkg.sv
// Shared definitions for the POV string reader: character geometry, reader states
// and the character extraction helper.
package pov_pkg;

    localparam int CHAR_W = 7;
    localparam int NCHARS = 11;
    localparam int STR_W  = NCHARS * CHAR_W;
    localparam int IDX_W  = $clog2(NCHARS + 1);

    localparam logic [CHAR_W-1:0] NUL_CHAR = 7'h00;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_SYNC,
        SEND,
        GAP
    } reader_state_t;

    // Out-of-range indices read as NUL so idx==NCHARS naturally terminates a frame.
    function automatic logic [CHAR_W-1:0] char_at(input logic [STR_W-1:0] s,
                                                  input logic [IDX_W-1:0] idx);
        logic [CHAR_W-1:0] c;
        c = NUL_CHAR;
        for (int k = 0; k < NCHARS; k++) begin
            if (idx == IDX_W'(k)) c = s[CHAR_W*k +: CHAR_W];
        end
        return c;
    endfunction

endpackage

// File: rtl/pov_sync_edge.sv
// Two-flop synchronizer for an asynchronous sensor input, followed by a
// single-clock rising-edge pulse.
module pov_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic rise
);

    // sh[0], sh[1] form the synchronizer; sh[2] holds the previous synced value.
    logic [2:0] sh;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh <= '0;
        end else begin
            sh <= {sh[1:0], din};
        end
    end

    assign rise = sh[1] & ~sh[2];

endmodule

// File: rtl/pov_string_reader.sv
// Snapshots a completed character string and plays it out one character per
// rotation sync pulse to the glyph renderer. Character geometry comes from pov_pkg.
module pov_string_reader
    import pov_pkg::*;
#(
    parameter int GAP_CYCLES = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [STR_W-1:0]    str,
    input  logic                complete,
    input  logic                change,
    input  logic                sync,
    input  logic                char_ready,
    output logic [CHAR_W-1:0]   char_out,
    output logic                char_valid,
    output logic                frame_active,
    output logic                frame_done,
    output logic                overrun,
    output reader_state_t       dbg_state
);

    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = (GAP_CYCLES > 0) ? GAP_W'(GAP_CYCLES - 1) : '0;

    reader_state_t      state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic [STR_W-1:0]   snap_q, snap_d;
    logic [STR_W-1:0]   pend_q, pend_d;
    logic               snap_valid_q, snap_valid_d;
    logic               pending_q, pending_d;
    logic               frame_done_q, frame_done_d;
    logic               overrun_q, overrun_d;
    logic               swap;

    logic               sync_rise;
    logic [CHAR_W-1:0]  cur_char;
    logic               at_end;
    logic               xfer;

    pov_sync_edge u_sync_edge (
        .clk   (clk),
        .rst_n (reset),
        .din   (sync),
        .rise  (sync_rise)
    );

    // Handshake: char_valid/char_out are functions of registered state only, so
    // char_out is stable while char_valid is high; a character is consumed on a
    // clock edge where char_valid && char_ready, and idx advances on that edge.
    assign cur_char     = char_at(snap_q, idx_q);
    assign at_end       = (idx_q == IDX_W'(NCHARS)) || (cur_char == NUL_CHAR);
    assign char_valid   = (state_q == SEND) && !at_end;
    assign char_out     = char_valid ? cur_char : NUL_CHAR;
    assign frame_active = (state_q == SEND) || (state_q == GAP);
    assign xfer         = char_valid && char_ready;
    assign frame_done   = frame_done_q;
    assign overrun      = overrun_q;
    assign dbg_state    = state_q;

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        gap_d        = gap_q;
        snap_d       = snap_q;
        pend_d       = pend_q;
        snap_valid_d = snap_valid_q;
        pending_d    = pending_q;
        frame_done_d = 1'b0;
        overrun_d    = 1'b0;
        swap         = 1'b0;

        // complete beats change, and takes effect at once outside a frame.
        if (complete && (change || !frame_active)) begin
            snap_d       = str;
            snap_valid_d = 1'b1;
            pending_d    = 1'b0;
            state_d      = WAIT_SYNC;
            idx_d        = '0;
            gap_d        = '0;
        end else if (change) begin
            snap_valid_d = 1'b0;
            pending_d    = 1'b0;
            state_d      = IDLE;
            idx_d        = '0;
            gap_d        = '0;
        end else begin
            case (state_q)
                WAIT_SYNC: begin
                    if (sync_rise && snap_valid_q) begin
                        idx_d   = '0;
                        state_d = SEND;
                    end
                end
                SEND, GAP: begin
                    if (sync_rise) begin
                        overrun_d = 1'b1;
                        swap      = 1'b1;
                        idx_d     = '0;
                        gap_d     = '0;
                        state_d   = SEND;
                    end else if (state_q == SEND) begin
                        if (at_end) begin
                            frame_done_d = 1'b1;
                            swap         = 1'b1;
                            idx_d        = '0;
                            state_d      = WAIT_SYNC;
                        end else if (xfer) begin
                            idx_d = idx_q + IDX_W'(1);
                            gap_d = '0;
                            if (GAP_CYCLES > 0) state_d = GAP;
                        end
                    end else begin
                        if (gap_q == GAP_LAST) state_d = SEND;
                        else                   gap_d   = gap_q + GAP_W'(1);
                    end
                end
                default: ;
            endcase

            // A string completed mid-frame waits in pend until the frame boundary.
            if (swap) begin
                if (complete)       snap_d = str;
                else if (pending_q) snap_d = pend_q;
                pending_d = 1'b0;
            end else if (complete) begin
                pend_d    = str;
                pending_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            gap_q        <= '0;
            snap_q       <= '0;
            pend_q       <= '0;
            snap_valid_q <= 1'b0;
            pending_q    <= 1'b0;
            frame_done_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            gap_q        <= gap_d;
            snap_q       <= snap_d;
            pend_q       <= pend_d;
            snap_valid_q <= snap_valid_d;
            pending_q    <= pending_d;
            frame_done_q <= frame_done_d;
            overrun_q    <= overrun_d;
        end
    end

endmodule
